// File: rtl/simple_bus_responder.sv
// Target end of the simple_bus request/acknowledge protocol: services single reads/writes
// from a small register file after LATENCY cycles. Define SIMPLE_BUS_RESP_PARITY_EN for per-register parity.
module simple_bus_responder #(
   parameter int WIDTH   = 7,
   parameter int ADDR_W  = 2,
   parameter int DEPTH   = 4,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic              ack,
   output logic [WIDTH-1:0]  rdata,
   output logic              err,
   output logic              busy
`ifdef SIMPLE_BUS_RESP_PARITY_EN
   ,
   output logic              rdata_par
`endif
);

   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 2) ? (LATENCY - 2) : 0);
   localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   function automatic logic parity(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [WIDTH-1:0]  mem_d [DEPTH];

   logic              in_range;
   logic              do_write;
   logic [WIDTH-1:0]  rd_word;
   logic              par_bad;

   // Only the captured copy of the request is ever looked at after acceptance.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               cnt_d   = CNT_LOAD;
               state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
   assign do_write = (state_q == S_RESP) && we_q && in_range;

   // Decoded read mux avoids indexing past DEPTH when it is not a power of two.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr_q == ADDR_W'(i)) begin
            rd_word = mem_q[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (do_write && (addr_q == ADDR_W'(i))) begin
            mem_d[i] = wdata_q;
         end
      end
   end

`ifdef SIMPLE_BUS_RESP_PARITY_EN
   logic par_q [DEPTH];
   logic par_d [DEPTH];
   logic rd_par;

   always_comb begin
      rd_par = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         par_d[i] = par_q[i];
         if (do_write && (addr_q == ADDR_W'(i))) begin
            par_d[i] = parity(wdata_q);
         end
         if (addr_q == ADDR_W'(i)) begin
            rd_par = par_q[i];
         end
      end
   end

   assign par_bad   = !we_q && in_range && (rd_par != parity(rd_word));
   assign rdata_par = parity(rdata);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q <= '{default: 1'b0};
      end else begin
         par_q <= par_d;
      end
   end
`else
   assign par_bad = 1'b0;
`endif

   // Outputs are decoded from registered state only, so they drop as soon as rst asserts.
   assign ack   = (state_q == S_RESP);
   assign busy  = (state_q != S_IDLE);
   assign rdata = (ack && !we_q && in_range) ? rd_word : '0;
   assign err   = ack && (!in_range || par_bad);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         mem_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         mem_q   <= mem_d;
      end
   end

endmodule
